// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 16-bit ALU between requesters A and B.
// Optional divide-by-zero trap enabled by defining ALU_ARB_DIV0_TRAP_EN.
module alu_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_a,
    input  logic        req_b,
    input  logic [3:0]  opcode_a,
    input  logic [3:0]  opcode_b,
    input  logic        ar_a,
    input  logic        ar_b,
    input  logic [15:0] src1_a,
    input  logic [15:0] src2_a,
    input  logic [15:0] src1_b,
    input  logic [15:0] src2_b,
    output logic        gnt_a,
    output logic        gnt_b,
    output logic        done_a,
    output logic        done_b,
    output logic [15:0] result,
    output logic [3:0]  res_flags,
    output logic        err,
    output logic        busy,
    output logic [3:0]  alu_opcode,
    output logic        alu_ar_flag,
    output logic [15:0] alu_src1,
    output logic [15:0] alu_src2,
    output logic        alu_out_en,
    input  logic [15:0] alu_out,
    input  logic [3:0]  alu_flags
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    // owner/last: 0 = A, 1 = B
    logic        owner;
    logic        last;

    logic [3:0]  opcode_q;
    logic        ar_q;
    logic [15:0] src1_q;
    logic [15:0] src2_q;

    logic        any_req;
    logic        pick_b;
    logic        grant;
    logic        trap;
    logic [3:0]  sel_opcode;
    logic        sel_ar;
    logic [15:0] sel_src1;
    logic [15:0] sel_src2;

    assign any_req = req_a | req_b;

    // B wins when alone, or on contention when A was served last
    assign pick_b = req_b & (~req_a | ~last);

    assign grant = (state == IDLE) & any_req;

    assign sel_opcode = pick_b ? opcode_b : opcode_a;
    assign sel_ar     = pick_b ? ar_b     : ar_a;
    assign sel_src1   = pick_b ? src1_b   : src1_a;
    assign sel_src2   = pick_b ? src2_b   : src2_a;

`ifdef ALU_ARB_DIV0_TRAP_EN
    assign trap = grant & (sel_opcode == 4'b0110) & (sel_src2 == 16'd0);
`else
    assign trap = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state sequencing through issue, wait and done
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (trap) begin
                    state_nxt = DONE;
                end else if (any_req) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE:   state_nxt = WAIT;
            WAIT:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Latch winner, round-robin pointer and operands at the grant edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner    <= 1'b0;
            last     <= 1'b1;
            opcode_q <= 4'd0;
            ar_q     <= 1'b0;
            src1_q   <= 16'd0;
            src2_q   <= 16'd0;
        end else if (grant) begin
            owner    <= pick_b;
            last     <= pick_b;
            opcode_q <= sel_opcode;
            ar_q     <= sel_ar;
            src1_q   <= sel_src1;
            src2_q   <= sel_src2;
        end
    end

    // Capture ALU result after ISSUE and registered flags after WAIT
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result    <= 16'd0;
            res_flags <= 4'd0;
        end else if (state == ISSUE) begin
            result    <= alu_out;
        end else if (state == WAIT) begin
            res_flags <= alu_flags;
        end else if (trap) begin
            result    <= 16'hFFFF;
            res_flags <= 4'd0;
        end
    end

`ifdef ALU_ARB_DIV0_TRAP_EN
    logic err_q;

    // Trap flag set on a trapped grant, cleared by any issued operation
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (trap) begin
            err_q <= 1'b1;
        end else if (state == ISSUE) begin
            err_q <= 1'b0;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Handshake outputs decoded from state and owner
    always_comb begin
        busy   = (state != IDLE);
        gnt_a  = busy & ~owner;
        gnt_b  = busy & owner;
        done_a = (state == DONE) & ~owner;
        done_b = (state == DONE) & owner;
    end

    // ALU port drive: zero while idle, latched operands otherwise
    always_comb begin
        alu_opcode  = 4'd0;
        alu_ar_flag = 1'b0;
        alu_src1    = 16'd0;
        alu_src2    = 16'd0;
        alu_out_en  = (state == ISSUE);
        if (state != IDLE) begin
            alu_opcode  = opcode_q;
            alu_ar_flag = ar_q;
            alu_src1    = src1_q;
            alu_src2    = src2_q;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU attached.
// Expectations follow ALU_ARB_DIV0_TRAP_EN when it is defined.
module tb_alu_arbiter;

    logic        clk;
    logic        rst;
    logic        req_a, req_b;
    logic [3:0]  opcode_a, opcode_b;
    logic        ar_a, ar_b;
    logic [15:0] src1_a, src2_a, src1_b, src2_b;
    logic        gnt_a, gnt_b, done_a, done_b;
    logic [15:0] result;
    logic [3:0]  res_flags;
    logic        err, busy;
    logic [3:0]  alu_opcode;
    logic        alu_ar_flag;
    logic [15:0] alu_src1, alu_src2;
    logic        alu_out_en;
    logic [15:0] alu_out;
    logic [3:0]  alu_flags;
    logic [3:0]  m_flags;

    int n_chk;
    int n_fail;
    int cyc;

    alu_arbiter dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .req_b(req_b),
        .opcode_a(opcode_a), .opcode_b(opcode_b),
        .ar_a(ar_a), .ar_b(ar_b),
        .src1_a(src1_a), .src2_a(src2_a),
        .src1_b(src1_b), .src2_b(src2_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b),
        .done_a(done_a), .done_b(done_b),
        .result(result), .res_flags(res_flags),
        .err(err), .busy(busy),
        .alu_opcode(alu_opcode), .alu_ar_flag(alu_ar_flag),
        .alu_src1(alu_src1), .alu_src2(alu_src2),
        .alu_out_en(alu_out_en),
        .alu_out(alu_out), .alu_flags(alu_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference ALU: add, sub, div; anything else yields zero
    always_comb begin
        logic [16:0] w;
        logic        c, o;
        w       = 17'd0;
        c       = 1'b0;
        o       = 1'b0;
        alu_out = 16'd0;
        if (alu_opcode == 4'b0011) begin
            w       = {1'b0, alu_src1} + {1'b0, alu_src2};
            alu_out = w[15:0];
            c       = w[16];
            o       = (alu_src1[15] == alu_src2[15]) &&
                      (alu_out[15] != alu_src1[15]);
        end else if (alu_opcode == 4'b0100) begin
            alu_out = alu_src1 - alu_src2;
            c       = alu_src1 < alu_src2;
            o       = (alu_src1[15] != alu_src2[15]) &&
                      (alu_out[15] != alu_src1[15]);
        end else if (alu_opcode == 4'b0110) begin
            alu_out = (alu_src2 == 16'd0) ? 16'hFFFF
                                          : alu_src1 / alu_src2;
        end
        m_flags = {o, c, alu_out[15], alu_out == 16'd0};
    end

    // ALU flags register, loaded while out_en is high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) alu_flags <= 4'd0;
        else if (alu_out_en) alu_flags <= m_flags;
    end

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          use_b;
        logic [3:0]  op;
        logic [15:0] s1;
        logic [15:0] s2;
        logic [15:0] res;
        logic [3:0]  flg;
    } vec_t;

    // One full 4-cycle transaction from a single requester
    task automatic run_vec(input vec_t v);
        @(negedge clk);
        if (v.use_b) begin
            req_b = 1; opcode_b = v.op; src1_b = v.s1; src2_b = v.s2;
        end else begin
            req_a = 1; opcode_a = v.op; src1_a = v.s1; src2_a = v.s2;
        end
        @(negedge clk);
        chk("gnt owner", v.use_b ? gnt_b : gnt_a, 1);
        chk("gnt other", v.use_b ? gnt_a : gnt_b, 0);
        chk("out_en issue", alu_out_en, 1);
        chk("alu_opcode", alu_opcode, v.op);
        chk("alu_src1", alu_src1, v.s1);
        chk("alu_src2", alu_src2, v.s2);
        @(negedge clk);
        chk("out_en wait", alu_out_en, 0);
        chk("result early", result, v.res);
        chk("done early", done_a | done_b, 0);
        @(negedge clk);
        chk("done owner", v.use_b ? done_b : done_a, 1);
        chk("done other", v.use_b ? done_a : done_b, 0);
        chk("result", result, v.res);
        chk("res_flags", res_flags, v.flg);
        chk("err", err, 0);
        req_a = 0;
        req_b = 0;
        @(negedge clk);
        chk("done end", done_a | done_b, 0);
        chk("busy end", busy, 0);
        chk("result hold", result, v.res);
    endtask

    vec_t vecs[6];
    int   t;
    int   last_cyc;
    bit   saw;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0; n_fail = 0; cyc = 0;
        rst = 0; req_a = 0; req_b = 0;
        opcode_a = 0; opcode_b = 0; ar_a = 0; ar_b = 0;
        src1_a = 0; src2_a = 0; src1_b = 0; src2_b = 0;

        vecs[0] = '{0, 4'b0011, 16'd5,     16'd7, 16'd12,    4'b0000};
        vecs[1] = '{1, 4'b0100, 16'd3,     16'd5, 16'hFFFE,  4'b0110};
        vecs[2] = '{0, 4'b0011, 16'h7FFF,  16'd1, 16'h8000,  4'b1010};
        vecs[3] = '{1, 4'b0011, 16'hFFFF,  16'd1, 16'h0000,  4'b0101};
        vecs[4] = '{0, 4'b1111, 16'h1234,  16'd9, 16'h0000,  4'b0001};
        vecs[5] = '{1, 4'b0100, 16'd5,     16'd5, 16'h0000,  4'b0001};

        repeat (2) @(negedge clk);
        chk("rst busy", busy, 0);
        chk("rst gnt", {gnt_a, gnt_b}, 0);
        chk("rst done", {done_a, done_b}, 0);
        chk("rst result", result, 0);
        chk("rst flags", res_flags, 0);
        chk("rst alu", {alu_opcode, alu_src1, alu_out_en}, 0);
        rst = 1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Contention: both held high, expect A, B, A at 4-cycle spacing
        @(negedge clk);
        req_a = 1; opcode_a = 4'b0011; src1_a = 1; src2_a = 1;
        req_b = 1; opcode_b = 4'b0011; src1_b = 2; src2_b = 2;
        last_cyc = 0;
        for (int k = 0; k < 3; k++) begin
            t = 0;
            while (!(gnt_a | gnt_b) && t < 10) begin
                @(negedge clk);
                t++;
            end
            chk("rr owner", {gnt_a, gnt_b}, (k == 1) ? 2'b01 : 2'b10);
            if (k > 0) chk("rr spacing", cyc - last_cyc, 4);
            last_cyc = cyc;
            t = 0;
            while (!(done_a | done_b) && t < 8) begin
                @(negedge clk);
                t++;
            end
            chk("rr result", result, (k == 1) ? 16'd4 : 16'd2);
            if (k == 2) begin
                req_a = 0;
                req_b = 0;
            end
            @(negedge clk);
            chk("rr idle", busy, 0);
        end

        // Operand changes after the grant edge are ignored
        @(negedge clk);
        req_a = 1; opcode_a = 4'b0011; src1_a = 5; src2_a = 7;
        @(negedge clk);
        src1_a = 100; src2_a = 0; opcode_a = 4'b0100;
        @(negedge clk);
        chk("latch src1", alu_src1, 5);
        @(negedge clk);
        chk("latch done", done_a, 1);
        chk("latch result", result, 12);
        req_a = 0;
        @(negedge clk);

        // Asynchronous reset while in WAIT
        req_a = 1; opcode_a = 4'b0011; src1_a = 2; src2_a = 3;
        @(negedge clk);
        @(negedge clk);
        chk("pre-rst result", result, 5);
        #2 rst = 0;
        #1;
        chk("arst busy", busy, 0);
        chk("arst gnt", {gnt_a, gnt_b}, 0);
        chk("arst result", result, 0);
        chk("arst alu", {alu_opcode, alu_src1, alu_src2, alu_out_en}, 0);
        saw = 0;
        req_a = 0;
        @(negedge clk);
        rst = 1;
        repeat (4) begin
            @(negedge clk);
            if (done_a | done_b) saw = 1;
        end
        chk("arst no done", saw, 0);
        run_vec(vecs[0]);

`ifdef ALU_ARB_DIV0_TRAP_EN
        @(negedge clk);
        req_a = 1; opcode_a = 4'b0110; src1_a = 9; src2_a = 0;
        @(negedge clk);
        chk("trap done", done_a, 1);
        chk("trap out_en", alu_out_en, 0);
        chk("trap result", result, 16'hFFFF);
        chk("trap flags", res_flags, 0);
        chk("trap err", err, 1);
        req_a = 0;
        @(negedge clk);
        chk("trap idle", busy, 0);
        chk("trap hold err", err, 1);
        run_vec(vecs[0]);
`else
        run_vec('{0, 4'b0110, 16'd9, 16'd0, 16'hFFFF, 4'b0010});
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single ALU between two requesters (A: instruction datapath, B: address/auxiliary unit) with a round-robin request/done handshake. Latches the winning requester's operands, drives the ALU operand, opcode and `out_en` ports, then captures the ALU result and the registered O/C/N/Z flags. Returns result and flags to the granted requester with a one-cycle done pulse. Sits between the requesters and the ALU instance; the ALU is never driven directly by a requester.

## Interface
- No parameters; data width fixed at 16, opcode 4, flags 4 (O C N Z).
- `clk` in 1: system clock, all state on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req_a`, `req_b` in 1: operation request, held high until the matching done.
- `opcode_a`, `opcode_b` in 4: ALU opcode (0011 add … 1011 shift right).
- `ar_a`, `ar_b` in 1: arithmetic/rotate select for shifts.
- `src1_a`, `src2_a`, `src1_b`, `src2_b` in 16: operands.
- `gnt_a`, `gnt_b` out 1: requester owns the ALU (ISSUE through DONE).
- `done_a`, `done_b` out 1: one-cycle pulse; `result`/`res_flags` valid.
- `result` out 16: captured ALU result.
- `res_flags` out 4: captured flags {O,C,N,Z}.
- `err` out 1: trap indication, valid with done.
- `busy` out 1: state != IDLE.
- `alu_opcode` out 4, `alu_ar_flag` out 1, `alu_src1`/`alu_src2` out 16, `alu_out_en` out 1: to the ALU.
- `alu_out` in 16, `alu_flags` in 4: from the ALU (`alu_out` combinational, `alu_flags` registered on `out_en`).

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: samples `req_a`/`req_b`. One requester high: grant it. Both high: grant the requester not granted last (`last` bit), then update `last`. On grant, latch opcode, ar and operands into internal registers and go to ISSUE.
- ISSUE: `alu_*` ports driven from the latched registers, `alu_out_en`=1. At the end edge capture `alu_out` into `result` → WAIT.
- WAIT: `alu_out_en`=0, ALU ports hold the latched values. At the end edge capture `alu_flags` into `res_flags` → DONE.
- DONE: the granted requester's done=1 for exactly one cycle → IDLE.
- `alu_*` outputs are 0 in IDLE. `alu_out_en` is high only in ISSUE.
- Operands are sampled only at the grant edge. Requester changes after that edge are ignored.
- Requesters drop req on the edge that ends their done cycle. A req still high in the following IDLE is a new request.
- Opcodes outside 0011..1011 are issued unchanged. The ALU returns 0 with Z=1.
- Reset asserted at any time: state → IDLE immediately. All outputs → 0, `last` → B (A wins the first contention), latched registers → 0. No done is produced for the aborted operation.

## Timing
- Grant at edge N. `alu_out_en` high in cycle N..N+1. `result` valid from edge N+1. `done`/`res_flags` valid in cycle N+2..N+3.
- Earliest next grant: edge N+4. Throughput is one operation per 4 cycles.
- `gnt_x` high from edge N to edge N+3. `busy` high over the same interval.
- `result`, `res_flags` and `err` hold their values after DONE until the next capture.

## Configuration
- `ALU_ARB_DIV0_TRAP_EN` defined:
  - In IDLE, a granted request with opcode 0110 and src2==0 goes directly to DONE; the ALU is not issued (`alu_out_en` stays 0).
  - `result`=16'hFFFF, `res_flags`=4'b0000, `err`=1, done in cycle N..N+1.
  - `err`=0 for every other operation.
- Undefined: `err` is tied 0. Divide by zero is issued normally to the ALU.

## Test plan
- Reset then `req_a`, add 5+7: `gnt_a` at edge N, `alu_out_en` one cycle, `done_a` in N+2..N+3, `result`=12, `res_flags`=0000.
- `req_b` only, sub 3−5: `done_b` pulses once, `result`=16'hFFFE, N=1, C=1.
- `req_a` and `req_b` both high for three operations: grant order A, B, A. Grants occur at edges N, N+4, N+8.
- Change `src1_a` during ISSUE: `result` reflects the value latched at grant.
- Reset pulled low during WAIT: all outputs 0 asynchronously, no done, next `req_a` served normally.
- With `ALU_ARB_DIV0_TRAP_EN`, `req_a` div 9/0: `alu_out_en` never high, `done_a` after one edge, `result`=16'hFFFF, `err`=1. Without the macro: normal 4-cycle sequence, `err`=0.
